// File: rtl/ifetch_if.sv
// Bundle of the fetch stage's imem request port, decode handshake and redirect input.
// master = fetch stage, slave = surrounding datapath (imem, decode, execute).
interface ifetch_if;
    logic        imem_memrq;
    logic        imem_rnw;
    logic [31:0] imem_pc;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        misalign;
    logic [1:0]  fill_state;

    modport master (
        output imem_memrq, imem_rnw, imem_pc,
        input  imem_data,
        input  redirect, redirect_pc,
        input  id_ready,
        output id_valid, id_instr, id_pc,
        output misalign, fill_state
    );

    modport slave (
        input  imem_memrq, imem_rnw, imem_pc,
        output imem_data,
        output redirect, redirect_pc,
        output id_ready,
        input  id_valid, id_instr, id_pc,
        input  misalign, fill_state
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, reads imem, queues words in a 2-entry buffer for decode.
// A redirect from execute flushes the buffer and restarts fetch at the (word-aligned) target.
module ifetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic     clk,
    input  logic     reset,
    ifetch_if.master bus
);
    // Decode handshake: an entry moves to decode in any cycle where id_valid and
    // id_ready are both 1 at the rising edge; id_valid depends only on registered
    // state, and id_instr/id_pc stay stable while id_valid is held without id_ready.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_t;

    fill_t       state_q, state_next;
    logic [31:0] pc;
    logic        rd_ptr, wr_ptr;
    logic        misalign_q;
    logic [31:0] buf_pc    [2];
    logic [31:0] buf_instr [2];
    logic        pop, fetch;

    assign pop   = bus.id_valid & bus.id_ready;
    assign fetch = reset & ~bus.redirect & ((state_q != FULL) | pop);

    assign bus.imem_memrq = fetch;
    assign bus.imem_rnw   = 1'b1;
    assign bus.imem_pc    = pc;
    assign bus.id_valid   = (state_q != EMPTY);
    assign bus.id_instr   = bus.id_valid ? buf_instr[rd_ptr] : NOP_INSTR;
    assign bus.id_pc      = bus.id_valid ? buf_pc[rd_ptr]    : pc;
    assign bus.misalign   = misalign_q;
    assign bus.fill_state = state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_next;
        end
    end

    // Simultaneous fetch and pop leave the fill level unchanged.
    always_comb begin
        state_next = state_q;
        if (bus.redirect) begin
            state_next = EMPTY;
        end else if (fetch && !pop) begin
            state_next = (state_q == EMPTY) ? ONE : FULL;
        end else if (pop && !fetch) begin
            state_next = (state_q == FULL) ? ONE : EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc         <= RESET_PC;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= bus.redirect & (|bus.redirect_pc[1:0]);
            if (bus.redirect) begin
                pc     <= {bus.redirect_pc[31:2], 2'b00};
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (fetch) begin
                    wr_ptr <= ~wr_ptr;
                    pc     <= pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end

    // Buffer storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (fetch) begin
            buf_pc[wr_ptr]    <= pc;
            buf_instr[wr_ptr] <= bus.imem_data;
        end
    end
endmodule
